// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   One-hot phase sequencer for the accumulate/clear loop. Each pass walks
//   LOAD -> DECIDE -> BODY1..BODYn -> WRITE. If clr_i is high in DECIDE, the
//   pass skips the body phases. Runs start from IDLE on start_i. A run ends
//   after the latched pass count, or after the current pass when stop_i is
//   seen in WRITE. hold_i freezes the whole machine.
//
// Ports
//   clk_i       clock, rising edge
//   reset_i     synchronous active-high reset
//   start_i     begin a run (IDLE only)
//   passes_i    pass count latched on start; 0 = run until stop
//   clr_i       skip body phases this pass (DECIDE only)
//   hold_i      stall: state, strobes, counter and target frozen
//   stop_i      finish after this pass (WRITE only)
//   s_o         one-hot strobes {WRITE, BODYn..BODY1, DECIDE, LOAD, IDLE}
//   busy_o      high outside IDLE
//   done_o      one-cycle pulse in the first IDLE cycle after the last WRITE
//   pass_cnt_o  passes completed in the current or last run
module ctrl_sequencer #(
   parameter int BODY   = 2,
   parameter int PASS_W = 8,
   parameter int NS     = BODY + 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [PASS_W-1:0] passes_i,
   input  logic              clr_i,
   input  logic              hold_i,
   input  logic              stop_i,
   output logic [NS-1:0]     s_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [PASS_W-1:0] pass_cnt_o
);

   // State is kept as a phase index; the index equals the strobe bit number.
   localparam int SW = $clog2(NS);
   localparam logic [SW-1:0] ST_IDLE   = SW'(0);
   localparam logic [SW-1:0] ST_LOAD   = SW'(1);
   localparam logic [SW-1:0] ST_DECIDE = SW'(2);
   localparam logic [SW-1:0] ST_BODY1  = SW'(3);
   localparam logic [SW-1:0] ST_WRITE  = SW'(BODY + 3);

   logic [SW-1:0]     state_q, state_d;
   logic [NS-1:0]     s_q, s_d;
   logic              done_q, done_d;
   logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [PASS_W-1:0] target_q, target_d;
   logic [PASS_W-1:0] cnt_inc;
   logic              last_pass;

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         s_q        <= NS'(1);
         done_q     <= 1'b0;
         pass_cnt_q <= '0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         done_q     <= done_d;
         pass_cnt_q <= pass_cnt_d;
         target_q   <= target_d;
      end
   end

   // A zero target never matches, so such a run ends only on stop_i.
   assign cnt_inc   = pass_cnt_q + PASS_W'(1);
   assign last_pass = stop_i || ((target_q != '0) && (cnt_inc == target_q));

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pass_cnt_d = pass_cnt_q;
      target_d   = target_q;
      done_d     = 1'b0;
      if (!hold_i) begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d    = ST_LOAD;
                  target_d   = passes_i;
                  pass_cnt_d = '0;
               end
            end
            ST_LOAD:   state_d = ST_DECIDE;
            ST_DECIDE: state_d = clr_i ? ST_WRITE : ST_BODY1;
            ST_WRITE: begin
               pass_cnt_d = cnt_inc;
               if (last_pass) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
            // Body phases step by one; the last body phase lands on WRITE.
            // Unused encodings fall back to IDLE.
            default:   state_d = (state_q < ST_WRITE) ? state_q + SW'(1) : ST_IDLE;
         endcase
      end
   end

   // Strobes are registered so s_o comes straight from flops.
   always_comb begin
      s_d = '0;
      for (int i = 0; i < NS; i++) s_d[i] = (state_d == SW'(i));
   end

   // Output logic
   always_comb begin
      s_o        = s_q;
      busy_o     = ~s_q[0];
      done_o     = done_q & ~hold_i;
      pass_cnt_o = pass_cnt_q;
   end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer at default parameters (BODY=2, NS=6).
// Each run is a table of per-cycle controls {reset,hold,stop,clr,start} and
// the hand-derived strobe value expected after each clock edge.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       reset_i = 1'b1;
   logic       start_i = 1'b0;
   logic [7:0] passes_i = '0;
   logic       clr_i = 1'b0;
   logic       hold_i = 1'b0;
   logic       stop_i = 1'b0;
   logic [5:0] s_o;
   logic       busy_o;
   logic       done_o;
   logic [7:0] pass_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   logic [4:0] cq[$];
   logic [5:0] eq[$];
   int         chg_at  = -1;
   logic [7:0] chg_val = '0;
   int         busy_n  = 0;

   ctrl_sequencer dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .start_i    (start_i),
      .passes_i   (passes_i),
      .clr_i      (clr_i),
      .hold_i     (hold_i),
      .stop_i     (stop_i),
      .s_o        (s_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .pass_cnt_o (pass_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic setup(input int n);
      cq = {};
      for (int i = 0; i < n; i++) cq.push_back(5'b00000);
   endtask

   // Every run starts from IDLE; DONE is expected only right after WRITE.
   task automatic run_seq(input string tag);
      logic [5:0] prev;
      prev   = 6'h01;
      busy_n = 0;
      for (int i = 0; i < eq.size(); i++) begin
         {reset_i, hold_i, stop_i, clr_i, start_i} = cq[i];
         if (i == chg_at) passes_i = chg_val;
         step();
         chk($sformatf("%s_s[%0d]", tag, i), 32'(s_o), 32'(eq[i]));
         chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy_o), 32'(eq[i] != 6'h01));
         chk($sformatf("%s_done[%0d]", tag, i), 32'(done_o),
             32'((eq[i] == 6'h01) && (prev == 6'h20) && !cq[i][4]));
         chk($sformatf("%s_onehot[%0d]", tag, i), 32'($onehot(s_o)), 32'd1);
         if (busy_o) busy_n++;
         prev = eq[i];
      end
      {reset_i, hold_i, stop_i, clr_i, start_i} = 5'b00000;
      chg_at = -1;
   endtask

   initial begin
      // Reset held 3 cycles with START high: must stay IDLE
      start_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_s", 32'(s_o), 32'h01);
         chk("rst_busy", 32'(busy_o), 32'd0);
         chk("rst_done", 32'(done_o), 32'd0);
         chk("rst_cnt", 32'(pass_cnt_o), 32'd0);
      end
      reset_i = 1'b0;
      start_i = 1'b0;
      step();
      chk("idle_s", 32'(s_o), 32'h01);

      // Two plain passes; PASSES changed mid-run must not matter
      passes_i = 8'd2;
      setup(12);
      cq[0] = 5'b00001;
      eq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20,
             6'h01, 6'h01};
      chg_at  = 2;
      chg_val = 8'd7;
      run_seq("t1");
      chk("t1_cnt", 32'(pass_cnt_o), 32'd2);
      chk("t1_busy_cycles", 32'(busy_n), 32'd10);

      // Three passes, CLR in DECIDE of pass 2 (and once outside DECIDE)
      passes_i = 8'd3;
      setup(15);
      cq[0] = 5'b00001;
      cq[3] = 5'b00010;
      cq[7] = 5'b00010;
      eq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h02, 6'h04, 6'h20, 6'h02, 6'h04,
             6'h08, 6'h10, 6'h20, 6'h01, 6'h01};
      run_seq("t2");
      chk("t2_cnt", 32'(pass_cnt_o), 32'd3);

      // Unbounded run: counter wraps, stray STOP in LOAD ignored, STOP in pass 260
      passes_i = 8'd0;
      start_i  = 1'b1;
      step();
      start_i = 1'b0;
      for (int p = 1; p <= 260; p++) begin
         chk($sformatf("t3_load[%0d]", p), 32'(s_o), 32'h02);
         if (p == 10) stop_i = 1'b1;
         step();
         stop_i = 1'b0;
         chk($sformatf("t3_decide[%0d]", p), 32'(s_o), 32'h04);
         step();
         step();
         step();
         chk($sformatf("t3_write[%0d]", p), 32'(s_o), 32'h20);
         if (p == 260) stop_i = 1'b1;
         step();
         stop_i = 1'b0;
         chk($sformatf("t3_cnt[%0d]", p), 32'(pass_cnt_o), 32'(p % 256));
         chk($sformatf("t3_done[%0d]", p), 32'(done_o), 32'(p == 260));
      end
      chk("t3_end_s", 32'(s_o), 32'h01);
      step();
      chk("t3_done_off", 32'(done_o), 32'd0);
      chk("t3_cnt_final", 32'(pass_cnt_o), 32'd4);

      // HOLD four cycles in BODY1; START pulses while busy ignored
      passes_i = 8'd1;
      setup(11);
      cq[0] = 5'b00001;
      cq[3] = 5'b01000;
      cq[4] = 5'b01001;
      cq[5] = 5'b01000;
      cq[6] = 5'b01000;
      cq[8] = 5'b00001;
      cq[9] = 5'b00001;
      eq = '{6'h02, 6'h04, 6'h08, 6'h08, 6'h08, 6'h08, 6'h08, 6'h10, 6'h20, 6'h01,
             6'h01};
      run_seq("t4");
      chk("t4_cnt", 32'(pass_cnt_o), 32'd1);

      // RESET in BODY2 of pass 1: IDLE next cycle, no DONE, counter cleared
      passes_i = 8'd5;
      setup(6);
      cq[0] = 5'b00001;
      cq[4] = 5'b10000;
      eq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h01, 6'h01};
      run_seq("t5");
      chk("t5_cnt", 32'(pass_cnt_o), 32'd0);

      // Fresh run after reset: CLR pass, then restart in the DONE cycle
      passes_i = 8'd1;
      setup(11);
      cq[0] = 5'b00001;
      cq[2] = 5'b00010;
      cq[4] = 5'b00001;
      eq = '{6'h02, 6'h04, 6'h20, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01,
             6'h01};
      run_seq("t6");
      chk("t6_cnt", 32'(pass_cnt_o), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
